// File: rtl/handshake_sink_if.sv
// Two-phase toggle handshake link: dir1 drives requests/payload on port1,
// dir2 returns acknowledge/credit on port2.
interface handshake #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] port1;
  logic [WIDTH-1:0] port2;

  modport dir1 (output port1, input port2);
  modport dir2 (input port1, output port2);
endinterface

// File: rtl/handshake_sink.sv
// Responder end of the toggle handshake: buffers accepted payload words in a
// small FIFO and presents them downstream as a valid/ready stream.
module handshake_sink #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  handshake.dir2                   inf,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-2:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         accept_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = WIDTH - 1;

  typedef enum logic {RUN, FULL} state_t;

  state_t          state;
  logic            ack_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   mem [DEPTH];

  logic            req;
  logic            pending;
  logic            accept;
  logic            pop;
  logic [LW-1:0]   level_nxt;
  logic [LW-1:0]   free;

  assign req       = inf.port1[WIDTH-1];
  assign pending   = req ^ ack_q;
  assign accept    = (state == RUN) && pending && !flush;
  assign pop       = out_valid && out_ready;
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Credit is derived from registered occupancy only, never from port1.
  assign free      = LW'(DEPTH) - level;
  assign inf.port2 = {ack_q, CW'(free)};

  always_comb begin
    level_nxt = level;
    case ({accept, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      ack_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      accept_cnt <= '0;
    end else if (flush) begin
      // Flush empties the FIFO but leaves ack_q alone, so a pending word survives.
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        ack_q  <= req;
        if (accept_cnt != '1)
          accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
      state <= (level_nxt == LW'(DEPTH)) ? FULL : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept)
      mem[wr_ptr] <= inf.port1[CW-1:0];
  end

endmodule
